arbitro_vc: RTL and testbench

- Four-channel round-robin arbiter that sits directly downstream of the QoS block.
- Pops words from the four virtual-channel source FIFOs and forwards them, tagged with their channel, to the four destination FIFOs.
- Honours the per-channel pausa/continuar requests and the error indication produced by QoS.
- One word is transferred per granted cycle; paused, empty or just-granted channels are skipped.

---
 rtl/arbitro_vc.sv | 178 +++++++++++++++++
 tb/tb_arbitro_vc.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_vc.sv
// arbitro_vc: four-channel round-robin arbiter between the QoS block and the
// destination FIFO bank.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-low reset
//   enb            global enable (0 = no new grants)
//   error_in       QoS error; moves ACTIVO to the sticky ERROR state
//   idle_in        QoS idle indication (only gates push_out when nothing is in flight)
//   pausa_in       per-channel pause request
//   continuar_in   per-channel resume request
//   empty_in       source FIFO empty flags
//   data_in        source FIFO read data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   pop_out        one-hot source FIFO read strobe
//   push_out       destination write strobe
//   dest_out       destination channel index for the pushed word
//   data_out       pushed word
//   paused_out     per-channel paused flags
//   estado_out     FSM state (00 INICIO, 01 ACTIVO, 10 ERROR)

// Per-channel paused flag: pausa sets, continuar clears, pausa wins a tie.
module arbitro_vc_pausa (
    input  logic clk,
    input  logic rst,
    input  logic pausa_in,
    input  logic continuar_in,
    output logic paused_out
);
    logic paused_d, paused_q;

    always_comb begin
        paused_d = paused_q;
        if (pausa_in)
            paused_d = 1'b1;
        else if (continuar_in)
            paused_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            paused_q <= 1'b0;
        else
            paused_q <= paused_d;
    end

    assign paused_out = paused_q;
endmodule

module arbitro_vc #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_VC     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enb,
    input  logic                    error_in,
    input  logic                    idle_in,
    input  logic [3:0]              pausa_in,
    input  logic [3:0]              continuar_in,
    input  logic [3:0]              empty_in,
    input  logic [4*DATA_WIDTH-1:0] data_in,
    output logic [3:0]              pop_out,
    output logic                    push_out,
    output logic [1:0]              dest_out,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [3:0]              paused_out,
    output logic [1:0]              estado_out
);
    typedef enum logic [1:0] {
        INICIO = 2'b00,
        ACTIVO = 2'b01,
        ERROR  = 2'b10
    } estado_t;

    estado_t               estado_q, estado_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [3:0]            pop_q, pop_d;
    logic [1:0]            pop_chan_q;    // index of the channel in pop_q
    logic                  vld1_q;        // popped last cycle: data_in valid now
    logic [1:0]            chan1_q;
    logic                  push_q, push_d;
    logic [1:0]            dest_q, dest_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [3:0]            paused;
    logic [3:0]            elig;
    logic                  grant_en;
    logic                  gnt_vld;
    logic [1:0]            gnt_idx;
    logic [1:0]            cand;
    logic                  in_flight;
    logic [DATA_WIDTH-1:0] data_vc [NUM_VC];

    // error_in overrides everything, including a grant in the same cycle.
    assign grant_en = (estado_q == ACTIVO) && enb && !error_in;

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        arbitro_vc_pausa u_pausa (
            .clk          (clk),
            .rst          (rst),
            .pausa_in     (pausa_in[i]),
            .continuar_in (continuar_in[i]),
            .paused_out   (paused[i])
        );
        // A channel popped this cycle is skipped: its empty flag lags by one.
        assign elig[i]    = grant_en & ~empty_in[i] & ~paused[i] & ~pop_q[i];
        assign data_vc[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIO:  if (enb) estado_d = ACTIVO;
            ACTIVO:  if (error_in) estado_d = ERROR;
            default: estado_d = ERROR;
        endcase
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        cand    = '0;
        for (int k = 1; k <= NUM_VC; k++) begin
            cand = ptr_q + 2'(k);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        pop_d = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
        ptr_d = gnt_vld ? gnt_idx : ptr_q;
    end

    // push_out follows the popped word two cycles later; idle_in can only
    // block a push when nothing is in flight, which never produces one anyway.
    assign in_flight = (|pop_q) | vld1_q;

    always_comb begin
        push_d = vld1_q & (~idle_in | in_flight);
        dest_d = dest_q;
        data_d = data_q;
        if (push_d) begin
            dest_d = chan1_q;
            data_d = data_vc[chan1_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q   <= INICIO;
            ptr_q      <= 2'd3;
            pop_q      <= '0;
            pop_chan_q <= '0;
            vld1_q     <= 1'b0;
            chan1_q    <= '0;
            push_q     <= 1'b0;
            dest_q     <= '0;
            data_q     <= '0;
        end else begin
            estado_q   <= estado_d;
            ptr_q      <= ptr_d;
            pop_q      <= pop_d;
            pop_chan_q <= gnt_idx;
            vld1_q     <= |pop_q;
            chan1_q    <= pop_chan_q;
            push_q     <= push_d;
            dest_q     <= dest_d;
            data_q     <= data_d;
        end
    end

    assign pop_out    = pop_q;
    assign push_out   = push_q;
    assign dest_out   = dest_q;
    assign data_out   = data_q;
    assign paused_out = paused;
    assign estado_out = estado_q;
endmodule

// File: tb/tb_arbitro_vc.sv
module tb_arbitro_vc;
    localparam int W = 6;

    logic           clk = 1'b0;
    logic           rst, enb, error_in, idle_in;
    logic [3:0]     pausa_in, continuar_in, empty_in;
    logic [4*W-1:0] data_in;
    logic [3:0]     pop_out;
    logic           push_out;
    logic [1:0]     dest_out;
    logic [W-1:0]   data_out;
    logic [3:0]     paused_out;
    logic [1:0]     estado_out;

    arbitro_vc #(.DATA_WIDTH(W), .NUM_VC(4)) dut (
        .clk(clk), .rst(rst), .enb(enb), .error_in(error_in), .idle_in(idle_in),
        .pausa_in(pausa_in), .continuar_in(continuar_in), .empty_in(empty_in),
        .data_in(data_in), .pop_out(pop_out), .push_out(push_out),
        .dest_out(dest_out), .data_out(data_out), .paused_out(paused_out),
        .estado_out(estado_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: channel indices as ints, -1 meaning "none".
    int           m_state;   // 0 INICIO, 1 ACTIVO, 2 ERROR
    bit [3:0]     m_paused;
    int           m_last;    // last granted channel
    int           m_pop;     // channel being popped this cycle
    int           m_stage;   // channel popped one cycle ago (its data is on data_in)
    bit           m_push;
    int           m_dest;
    logic [W-1:0] m_data;

    task automatic model_reset();
        m_state = 0; m_paused = '0; m_last = 3; m_pop = -1; m_stage = -1;
        m_push = 0; m_dest = 0; m_data = '0;
    endtask

    task automatic model_eval();
        int g = -1;
        int c;
        if (m_state == 1 && enb && !error_in)
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (g < 0 && !empty_in[c] && !m_paused[c] && c != m_pop) g = c;
            end
        if (m_stage >= 0) begin
            m_push = 1; m_dest = m_stage; m_data = data_in[m_stage*W +: W];
        end else
            m_push = 0;
        m_stage = m_pop;
        m_pop   = g;
        if (g >= 0) m_last = g;
        for (int i = 0; i < 4; i++)
            if (pausa_in[i]) m_paused[i] = 1;
            else if (continuar_in[i]) m_paused[i] = 0;
        if (m_state == 0 && enb) m_state = 1;
        else if (m_state == 1 && error_in) m_state = 2;
    endtask

    function automatic logic [18:0] mdl_vec();
        logic [3:0] p;
        p = (m_pop >= 0) ? 4'(1 << m_pop) : 4'b0000;
        return {p, m_push, 2'(m_dest), m_data, m_paused, 2'(m_state)};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {pop_out, push_out, dest_out, data_out, paused_out, estado_out};
    endfunction

    // One clock: inputs already stable, outputs observed on the falling edge.
    task automatic tick();
        model_eval();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        enb = 0; error_in = 0; idle_in = 0; pausa_in = 0; continuar_in = 0;
        empty_in = 4'hF; data_in = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0; model_reset();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        n_chk++;
        if (dut_vec() !== 19'd0) $display("FAIL reset_state got=%h exp=%h", dut_vec(), 19'd0);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        enb = 1; empty_in = 4'b1110;
        data_in = {$urandom_range(63, 0) & 18'h3FFFF, 6'h15};
        for (int t = 1; t <= 8; t++) begin
            tick();
            n_chk++;
            if (dut_vec() !== mdl_vec()) $display("FAIL single_t%0d got=%h exp=%h", t, dut_vec(), mdl_vec());
            else n_pass++;
            if (t == 1) begin
                n_chk++;
                if (estado_out !== 2'b01) $display("FAIL single_estado got=%b exp=01", estado_out);
                else n_pass++;
            end
            if (t == 2 || t == 3) begin
                n_chk++;
                if (pop_out !== ((t == 2) ? 4'b0001 : 4'b0000))
                    $display("FAIL single_pop_t%0d got=%b", t, pop_out);
                else n_pass++;
            end
            if (t == 4) begin
                n_chk++;
                if ({push_out, dest_out, data_out} !== {1'b1, 2'd0, 6'h15})
                    $display("FAIL single_push got=%b/%0d/%h exp=1/0/15", push_out, dest_out, data_out);
                else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        do_reset();
        enb = 1; empty_in = 4'b0000; data_in = 24'($urandom);
        tick();
        for (int t = 0; t < 8; t++) begin
            data_in = 24'($urandom);
            tick();
            n_chk++;
            if (dut_vec() !== mdl_vec()) $display("FAIL rr_t%0d got=%h exp=%h", t, dut_vec(), mdl_vec());
            else n_pass++;
            if (t < 5) begin
                n_chk++;
                if (pop_out !== exp_seq[t]) $display("FAIL rr_pop%0d got=%b exp=%b", t, pop_out, exp_seq[t]);
                else n_pass++;
            end
            if (t >= 2) begin
                n_chk++;
                if (push_out !== 1'b1 || dest_out !== 2'((t - 2) % 4))
                    $display("FAIL rr_push%0d got=%b/%0d exp=1/%0d", t, push_out, dest_out, (t - 2) % 4);
                else n_pass++;
            end
        end
    endtask

    task automatic test_pause();
        bit saw2 = 0;
        pausa_in = 4'b0100;
        tick();
        pausa_in = 0;
        n_chk++;
        if (paused_out !== 4'b0100) $display("FAIL pause_flag got=%b exp=0100", paused_out);
        else n_pass++;
        for (int t = 0; t < 12; t++) begin
            data_in = 24'($urandom);
            tick();
            n_chk++;
            if (dut_vec() !== mdl_vec()) $display("FAIL pause_t%0d got=%h exp=%h", t, dut_vec(), mdl_vec());
            else n_pass++;
            if (t >= 1) begin
                n_chk++;
                if (pop_out === 4'b0100) $display("FAIL pause_pop got=%b exp=not 0100", pop_out);
                else n_pass++;
            end
        end
        continuar_in = 4'b0100;
        tick();
        continuar_in = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (pop_out === 4'b0100) saw2 = 1;
            n_chk++;
            if (dut_vec() !== mdl_vec()) $display("FAIL resume_t%0d got=%h exp=%h", t, dut_vec(), mdl_vec());
            else n_pass++;
        end
        n_chk++;
        if (!saw2) $display("FAIL resume_ch2 got=absent exp=present");
        else n_pass++;
        pausa_in = 4'b0010; continuar_in = 4'b0010;
        tick();
        pausa_in = 0; continuar_in = 0;
        n_chk++;
        if (paused_out[1] !== 1'b1) $display("FAIL pause_wins got=%b exp=1", paused_out[1]);
        else n_pass++;
        continuar_in = 4'b0010;
        tick();
        continuar_in = 0;
    endtask

    task automatic test_error();
        error_in = 1;
        tick();
        n_chk++;
        if (estado_out !== 2'b10 || pop_out !== 4'b0000)
            $display("FAIL error_enter got=%b/%b exp=10/0000", estado_out, pop_out);
        else n_pass++;
        error_in = 0;
        for (int t = 0; t < 5; t++) begin
            data_in = 24'($urandom);
            tick();
            n_chk++;
            if (dut_vec() !== mdl_vec()) $display("FAIL error_t%0d got=%h exp=%h", t, dut_vec(), mdl_vec());
            else n_pass++;
            n_chk++;
            if (estado_out !== 2'b10 || pop_out !== 4'b0000)
                $display("FAIL error_sticky%0d got=%b/%b exp=10/0000", t, estado_out, pop_out);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        enb = 1; empty_in = 4'b0000; data_in = 24'($urandom);
        for (int t = 0; t < 5; t++) tick();
        #2 rst = 0;
        #1 model_reset();
        n_chk++;
        if (dut_vec() !== 19'd0) $display("FAIL async_reset got=%h exp=%h", dut_vec(), 19'd0);
        else n_pass++;
        @(negedge clk);
        rst = 1;
        for (int t = 0; t < 4; t++) begin
            tick();
            n_chk++;
            if (dut_vec() !== mdl_vec()) $display("FAIL postrst_t%0d got=%h exp=%h", t, dut_vec(), mdl_vec());
            else n_pass++;
            if (t == 1) begin
                n_chk++;
                if (pop_out !== 4'b0001) $display("FAIL postrst_first got=%b exp=0001", pop_out);
                else n_pass++;
            end
        end
    endtask

    task automatic test_enb_toggle();
        do_reset();
        enb = 1; empty_in = 4'b0101; data_in = 24'($urandom);
        for (int t = 0; t < 5; t++) tick();
        enb = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            n_chk++;
            if (dut_vec() !== mdl_vec()) $display("FAIL enb_off_t%0d got=%h exp=%h", t, dut_vec(), mdl_vec());
            else n_pass++;
            if (t >= 1) begin
                n_chk++;
                if (pop_out !== 4'b0000) $display("FAIL enb_off_pop got=%b exp=0000", pop_out);
                else n_pass++;
            end
        end
        enb = 1;
        for (int t = 0; t < 6; t++) begin
            tick();
            n_chk++;
            if (dut_vec() !== mdl_vec()) $display("FAIL enb_on_t%0d got=%h exp=%h", t, dut_vec(), mdl_vec());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 400; t++) begin
            enb          = ($urandom_range(9, 0) != 0);
            empty_in     = 4'($urandom);
            pausa_in     = ($urandom_range(5, 0) == 0) ? 4'($urandom) : 4'b0;
            continuar_in = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'b0;
            idle_in      = 1'($urandom);
            data_in      = 24'($urandom);
            error_in     = (t > 350) && ($urandom_range(15, 0) == 0);
            tick();
            n_chk++;
            if (dut_vec() !== mdl_vec()) $display("FAIL random_t%0d got=%h exp=%h", t, dut_vec(), mdl_vec());
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_pause();
        test_error();
        test_async_reset();
        test_enb_toggle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
